// File: rtl/rat_mw.sv
// rat_mw: multi-way register alias table with intra-group bypass, CDB wakeup
// and internal branch checkpoints that keep receiving wakeups while busy.
module rat_mw #(
    parameter int ROB_DEPTH      = 32,
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_PORTS      = 2,
    parameter int NUM_CKPT       = 4,
    localparam int PW = $clog2(ROB_DEPTH + 32),
    localparam int W  = DISPATCH_WIDTH,
    localparam int C  = CDB_PORTS,
    localparam int K  = NUM_CKPT,
    localparam int TW = (K > 1) ? $clog2(K) : 1,
    localparam int LW = (W > 1) ? $clog2(W) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    ren_we,
    input  logic [W*5-1:0]  ren_rd,
    input  logic [W*PW-1:0] ren_paddr,
    input  logic [W*5-1:0]  rs1_s,
    input  logic [W*5-1:0]  rs2_s,
    output logic [W-1:0]    rs1_valid,
    output logic [W-1:0]    rs2_valid,
    output logic [W*PW-1:0] rs1_paddr,
    output logic [W*PW-1:0] rs2_paddr,
    input  logic [C-1:0]    cdb_valid,
    input  logic [C*5-1:0]  cdb_aaddr,
    input  logic [C*PW-1:0] cdb_paddr,
    input  logic            ckpt_take,
    input  logic [LW-1:0]   ckpt_lane,
    output logic [TW-1:0]   ckpt_tag,
    output logic            ckpt_full,
    input  logic            ckpt_free,
    input  logic [TW-1:0]   ckpt_free_tag,
    input  logic            ckpt_restore,
    input  logic [TW-1:0]   ckpt_restore_tag
);

    logic [31:0]   valid_q, valid_d;
    logic [PW-1:0] paddr_q [32];
    logic [PW-1:0] paddr_d [32];
    logic [31:0]   ck_valid_q [K];
    logic [31:0]   ck_valid_d [K];
    logic [PW-1:0] ck_paddr_q [K][32];
    logic [PW-1:0] ck_paddr_d [K][32];
    logic [K-1:0]  busy_q, busy_d;
    logic [K-1:0]  older_q [K];
    logic [K-1:0]  older_d [K];

    logic [31:0]   snap_valid;
    logic [PW-1:0] snap_paddr [32];
    logic [K-1:0]  freed;

    // Any CDB port broadcasting (arch reg a, phys reg p) this cycle.
    function automatic logic cdb_hit(input logic [4:0] a, input logic [PW-1:0] p);
        logic h;
        h = 1'b0;
        for (int c = 0; c < C; c++) begin
            if (cdb_valid[c] && cdb_aaddr[c*5 +: 5] == a && cdb_paddr[c*PW +: PW] == p) h = 1'b1;
        end
        return h;
    endfunction

    // Source lookup: youngest older-lane rename wins, else the table entry
    // with same-cycle CDB forwarding; x0 is hardwired ready at p0.
    function automatic logic [PW:0] src_read(input int lane, input logic [4:0] s);
        logic [PW:0] r;
        r = {valid_q[s] | cdb_hit(s, paddr_q[s]), paddr_q[s]};
        for (int j = 0; j < W; j++) begin
            if (j < lane && ren_we[j] && ren_rd[j*5 +: 5] == s) r = {1'b0, ren_paddr[j*PW +: PW]};
        end
        if (s == 5'd0) r = {1'b1, {PW{1'b0}}};
        return r;
    endfunction

    // Lowest free checkpoint slot and full flag, from registered busy bits only.
    always_comb begin
        ckpt_tag = '0;
        for (int k = K - 1; k >= 0; k--) begin
            if (!busy_q[k]) ckpt_tag = TW'(k);
        end
        ckpt_full = &busy_q;
    end

    // Per-lane source reads with bypass and forwarding.
    always_comb begin
        rs1_valid = '0;
        rs2_valid = '0;
        rs1_paddr = '0;
        rs2_paddr = '0;
        for (int i = 0; i < W; i++) begin
            {rs1_valid[i], rs1_paddr[i*PW +: PW]} = src_read(i, rs1_s[i*5 +: 5]);
            {rs2_valid[i], rs2_paddr[i*PW +: PW]} = src_read(i, rs2_s[i*5 +: 5]);
        end
    end

    // Next-state for table and checkpoints: wakeups, renames, take/free, restore, reset.
    always_comb begin
        valid_d    = valid_q;
        paddr_d    = paddr_q;
        ck_valid_d = ck_valid_q;
        ck_paddr_d = ck_paddr_q;
        busy_d     = busy_q;
        older_d    = older_q;
        freed      = '0;

        for (int e = 1; e < 32; e++) begin
            valid_d[e] = valid_q[e] | cdb_hit(5'(e), paddr_q[e]);
        end
        // Idle slots are woken too; their contents are overwritten on take anyway.
        for (int k = 0; k < K; k++) begin
            for (int e = 1; e < 32; e++) begin
                ck_valid_d[k][e] = ck_valid_q[k][e] | cdb_hit(5'(e), ck_paddr_q[k][e]);
            end
        end

        snap_valid = valid_d;
        snap_paddr = paddr_d;
        // Ascending lane order so the highest lane wins a shared rd; the snapshot
        // only sees lanes up to and including the branch.
        for (int j = 0; j < W; j++) begin
            if (ren_we[j] && ren_rd[j*5 +: 5] != 5'd0) begin
                valid_d[ren_rd[j*5 +: 5]] = 1'b0;
                paddr_d[ren_rd[j*5 +: 5]] = ren_paddr[j*PW +: PW];
                if (j <= int'(ckpt_lane)) begin
                    snap_valid[ren_rd[j*5 +: 5]] = 1'b0;
                    snap_paddr[ren_rd[j*5 +: 5]] = ren_paddr[j*PW +: PW];
                end
            end
        end

        if (ckpt_restore) begin
            valid_d = ck_valid_d[ckpt_restore_tag];
            paddr_d = ck_paddr_q[ckpt_restore_tag];
            freed[ckpt_restore_tag] = 1'b1;
            for (int k = 0; k < K; k++) begin
                if (older_q[k][ckpt_restore_tag]) freed[k] = 1'b1;
            end
            busy_d = busy_q & ~freed;
            for (int k = 0; k < K; k++) begin
                older_d[k] = freed[k] ? '0 : (older_q[k] & ~freed);
            end
        end else begin
            if (ckpt_take && !ckpt_full) begin
                ck_valid_d[ckpt_tag] = snap_valid;
                ck_paddr_d[ckpt_tag] = snap_paddr;
                busy_d[ckpt_tag]     = 1'b1;
                older_d[ckpt_tag]    = busy_q;
            end
            // Guarded on busy so a stray free can never hit the slot being taken.
            if (ckpt_free && busy_q[ckpt_free_tag]) begin
                busy_d[ckpt_free_tag] = 1'b0;
                for (int k = 0; k < K; k++) begin
                    older_d[k][ckpt_free_tag] = 1'b0;
                end
            end
        end

        valid_d[0] = 1'b1;
        paddr_d[0] = '0;

        if (rst) begin
            valid_d = '1;
            busy_d  = '0;
            for (int e = 0; e < 32; e++) paddr_d[e] = '0;
            for (int k = 0; k < K; k++) begin
                ck_valid_d[k] = '1;
                older_d[k]    = '0;
                for (int e = 0; e < 32; e++) ck_paddr_d[k][e] = '0;
            end
        end
    end

    // State registers; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        paddr_q    <= paddr_d;
        ck_valid_q <= ck_valid_d;
        ck_paddr_q <= ck_paddr_d;
        busy_q     <= busy_d;
        older_q    <= older_d;
    end

endmodule

// File: tb/tb_rat_mw.sv
// Bench for rat_mw: directed vector table, a mid-operation reset, then random
// traffic against an age-ordered checkpoint reference model.
module tb_rat_mw;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ren_we;
    logic [9:0]  ren_rd;
    logic [11:0] ren_paddr;
    logic [9:0]  rs1_s, rs2_s;
    logic [1:0]  rs1_valid, rs2_valid;
    logic [11:0] rs1_paddr, rs2_paddr;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_aaddr;
    logic [11:0] cdb_paddr;
    logic        ckpt_take;
    logic [0:0]  ckpt_lane;
    logic [1:0]  ckpt_tag;
    logic        ckpt_full;
    logic        ckpt_free;
    logic [1:0]  ckpt_free_tag;
    logic        ckpt_restore;
    logic [1:0]  ckpt_restore_tag;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rat_mw dut (
        .clk(clk), .rst(rst),
        .ren_we(ren_we), .ren_rd(ren_rd), .ren_paddr(ren_paddr),
        .rs1_s(rs1_s), .rs2_s(rs2_s),
        .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
        .rs1_paddr(rs1_paddr), .rs2_paddr(rs2_paddr),
        .cdb_valid(cdb_valid), .cdb_aaddr(cdb_aaddr), .cdb_paddr(cdb_paddr),
        .ckpt_take(ckpt_take), .ckpt_lane(ckpt_lane),
        .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
        .ckpt_free(ckpt_free), .ckpt_free_tag(ckpt_free_tag),
        .ckpt_restore(ckpt_restore), .ckpt_restore_tag(ckpt_restore_tag)
    );

    typedef struct {
        logic [1:0] we;
        logic [4:0] rd0, rd1;
        logic [5:0] pa0, pa1;
        logic [4:0] s0, s1;
        logic       cv;
        logic [4:0] ca;
        logic [5:0] cp;
        logic       take, lane, free;
        logic [1:0] ftag;
        logic       rest;
        logic [1:0] rtag;
        logic [1:0] ev;
        logic [5:0] ep0, ep1;
        logic       efull;
        logic [1:0] etag;
    } vec_t;

    function automatic vec_t mk(int we, int rd0, int pa0, int rd1, int pa1, int s0, int s1,
                                int cv, int ca, int cp, int take, int lane, int free, int ftag,
                                int rest, int rtag, int ev, int ep0, int ep1, int efull, int etag);
        vec_t r;
        r.we = 2'(we); r.rd0 = 5'(rd0); r.pa0 = 6'(pa0); r.rd1 = 5'(rd1); r.pa1 = 6'(pa1);
        r.s0 = 5'(s0); r.s1 = 5'(s1); r.cv = 1'(cv); r.ca = 5'(ca); r.cp = 6'(cp);
        r.take = 1'(take); r.lane = 1'(lane); r.free = 1'(free); r.ftag = 2'(ftag);
        r.rest = 1'(rest); r.rtag = 2'(rtag); r.ev = 2'(ev); r.ep0 = 6'(ep0); r.ep1 = 6'(ep1);
        r.efull = 1'(efull); r.etag = 2'(etag);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; ren_we = '0; ren_rd = '0; ren_paddr = '0; rs1_s = '0; rs2_s = '0;
        cdb_valid = '0; cdb_aaddr = '0; cdb_paddr = '0; ckpt_take = 1'b0; ckpt_lane = '0;
        ckpt_free = 1'b0; ckpt_free_tag = '0; ckpt_restore = 1'b0; ckpt_restore_tag = '0;
    endtask

    // ---------------- reference model ----------------
    int mv[32], mp[32];
    int cb[4], cseq[4];
    int ckv[4][32], ckp[4][32];
    int seqn;

    task automatic model_reset();
        for (int e = 0; e < 32; e++) begin mv[e] = 1; mp[e] = 0; end
        for (int k = 0; k < 4; k++) cb[k] = 0;
        seqn = 0;
    endtask

    function automatic int woke(int a, int p);
        for (int c = 0; c < 2; c++)
            if (cdb_valid[c] && int'(cdb_aaddr[c*5 +: 5]) == a && int'(cdb_paddr[c*6 +: 6]) == p) return 1;
        return 0;
    endfunction

    function automatic int m_full();
        return (cb[0] + cb[1] + cb[2] + cb[3]) == 4 ? 1 : 0;
    endfunction

    function automatic int m_tag();
        for (int k = 0; k < 4; k++) if (cb[k] == 0) return k;
        return 0;
    endfunction

    // Returns valid*64 + paddr.
    function automatic int m_read(int i, int s);
        if (s == 0) return 64;
        for (int j = i - 1; j >= 0; j--)
            if (ren_we[j] && int'(ren_rd[j*5 +: 5]) == s) return int'(ren_paddr[j*6 +: 6]);
        return ((mv[s] != 0 || woke(s, mp[s]) != 0) ? 64 : 0) + mp[s];
    endfunction

    task automatic model_step();
        int nv[32], np[32], sv[32], sp[32];
        int t, tg, fl;
        if (rst) begin model_reset(); return; end
        tg = m_tag(); fl = m_full();
        for (int k = 0; k < 4; k++)
            if (cb[k] != 0)
                for (int e = 0; e < 32; e++) if (woke(e, ckp[k][e]) != 0) ckv[k][e] = 1;
        for (int e = 0; e < 32; e++) begin
            nv[e] = (mv[e] != 0 || woke(e, mp[e]) != 0) ? 1 : 0;
            np[e] = mp[e];
        end
        if (ckpt_restore) begin
            t = int'(ckpt_restore_tag);
            for (int e = 0; e < 32; e++) begin mv[e] = ckv[t][e]; mp[e] = ckp[t][e]; end
            for (int k = 0; k < 4; k++) if (cb[k] != 0 && cseq[k] > cseq[t]) cb[k] = 0;
            cb[t] = 0;
            return;
        end
        sv = nv; sp = np;
        for (int j = 0; j < 2; j++) begin
            int rd;
            rd = int'(ren_rd[j*5 +: 5]);
            if (ren_we[j] && rd != 0) begin
                nv[rd] = 0; np[rd] = int'(ren_paddr[j*6 +: 6]);
                if (j <= int'(ckpt_lane)) begin sv[rd] = 0; sp[rd] = np[rd]; end
            end
        end
        mv = nv; mp = np;
        if (ckpt_take && fl == 0) begin
            for (int e = 0; e < 32; e++) begin ckv[tg][e] = sv[e]; ckp[tg][e] = sp[e]; end
            cb[tg] = 1; cseq[tg] = seqn; seqn++;
        end
        if (ckpt_free) cb[int'(ckpt_free_tag)] = 0;
    endtask

    function automatic int pick_busy();
        int st;
        st = int'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) if (cb[(st + k) % 4] != 0) return (st + k) % 4;
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    vec_t vt[28];

    initial begin
        //            we rd0 pa0 rd1 pa1 s0 s1 cv ca cp tk ln fr ft rs rt ev ep0 ep1 fu tg
        vt[0]  = mk(0, 0, 0,  0, 0,  5, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[1]  = mk(3, 3, 40, 3, 41, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  40, 0, 0);
        vt[2]  = mk(0, 0, 0,  0, 0,  3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 41, 41, 0, 0);
        vt[3]  = mk(0, 0, 0,  0, 0,  3, 3, 1, 3, 40, 0, 0, 0, 0, 0, 0, 0, 41, 41, 0, 0);
        vt[4]  = mk(0, 0, 0,  0, 0,  3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 41, 41, 0, 0);
        vt[5]  = mk(1, 7, 50, 0, 0,  7, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  50, 0, 0);
        vt[6]  = mk(1, 7, 51, 0, 0,  7, 7, 1, 7, 50, 0, 0, 0, 0, 0, 0, 1, 50, 51, 0, 0);
        vt[7]  = mk(1, 7, 50, 0, 0,  7, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 51, 50, 0, 0);
        vt[8]  = mk(0, 0, 0,  0, 0,  7, 7, 1, 7, 50, 0, 0, 0, 0, 0, 0, 3, 50, 50, 0, 0);
        vt[9]  = mk(0, 0, 0,  0, 0,  7, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 50, 50, 0, 0);
        vt[10] = mk(3, 2, 33, 4, 34, 2, 4, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[11] = mk(0, 0, 0,  0, 0,  2, 4, 1, 2, 33, 0, 0, 0, 0, 0, 0, 1, 33, 34, 0, 1);
        vt[12] = mk(0, 0, 0,  0, 0,  2, 4, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 33, 34, 0, 1);
        vt[13] = mk(0, 0, 0,  0, 0,  2, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 33, 0,  0, 0);
        vt[14] = mk(0, 0, 0,  0, 0,  9, 9, 0, 0, 0,  1, 1, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[15] = mk(1, 9, 60, 0, 0,  9, 9, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1, 0,  60, 0, 1);
        vt[16] = mk(0, 0, 0,  0, 0,  9, 9, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[17] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[18] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 1);
        vt[19] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 2);
        vt[20] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 3);
        vt[21] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  1, 0);
        vt[22] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 3, 0,  0,  1, 0);
        vt[23] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 1);
        vt[24] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 3, 0,  0,  0, 1);
        vt[25] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[26] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 3, 0,  0,  0, 0);
        vt[27] = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0,  0,  0, 2);

        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int r = 0; r < 28; r++) begin
            idle();
            ren_we = vt[r].we; ren_rd = {vt[r].rd1, vt[r].rd0}; ren_paddr = {vt[r].pa1, vt[r].pa0};
            rs1_s = {vt[r].s1, vt[r].s0}; rs2_s = {vt[r].s1, vt[r].s0};
            cdb_valid = {1'b0, vt[r].cv}; cdb_aaddr = {5'd0, vt[r].ca}; cdb_paddr = {6'd0, vt[r].cp};
            ckpt_take = vt[r].take; ckpt_lane = vt[r].lane;
            ckpt_free = vt[r].free; ckpt_free_tag = vt[r].ftag;
            ckpt_restore = vt[r].rest; ckpt_restore_tag = vt[r].rtag;
            #3;
            chk($sformatf("vec%0d rs1_valid", r), int'(rs1_valid), int'(vt[r].ev));
            chk($sformatf("vec%0d rs1_paddr", r), int'(rs1_paddr), int'({vt[r].ep1, vt[r].ep0}));
            chk($sformatf("vec%0d rs2_valid", r), int'(rs2_valid), int'(vt[r].ev));
            chk($sformatf("vec%0d rs2_paddr", r), int'(rs2_paddr), int'({vt[r].ep1, vt[r].ep0}));
            chk($sformatf("vec%0d ckpt_full", r), int'(ckpt_full), int'(vt[r].efull));
            if (!vt[r].efull) chk($sformatf("vec%0d ckpt_tag", r), int'(ckpt_tag), int'(vt[r].etag));
            @(posedge clk); #1;
        end

        // Reset in the same cycle as a rename and a take: reset must win.
        idle();
        rst = 1'b1; ren_we = 2'b01; ren_rd = {5'd0, 5'd5}; ren_paddr = {6'd0, 6'd44}; ckpt_take = 1'b1;
        @(posedge clk); #1;
        idle();
        rs1_s = {5'd5, 5'd5}; rs2_s = {5'd3, 5'd7};
        #3;
        chk("midrst rs1_valid", int'(rs1_valid), 3);
        chk("midrst rs1_paddr", int'(rs1_paddr), 0);
        chk("midrst rs2_valid", int'(rs2_valid), 3);
        chk("midrst rs2_paddr", int'(rs2_paddr), 0);
        chk("midrst ckpt_full", int'(ckpt_full), 0);
        chk("midrst ckpt_tag", int'(ckpt_tag), 0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            int bt, ex;
            idle();
            rst = ($urandom_range(0, 149) == 0);
            for (int j = 0; j < 2; j++) begin
                ren_we[j] = ($urandom_range(0, 9) < 7);
                ren_rd[j*5 +: 5] = 5'($urandom_range(0, 7));
                ren_paddr[j*6 +: 6] = 6'($urandom_range(32, 39));
                rs1_s[j*5 +: 5] = 5'($urandom_range(0, 7));
                rs2_s[j*5 +: 5] = 5'($urandom_range(0, 7));
            end
            for (int c = 0; c < 2; c++) begin
                int a;
                a = int'($urandom_range(0, 7));
                cdb_valid[c] = $urandom_range(0, 1) == 1;
                cdb_aaddr[c*5 +: 5] = 5'(a);
                cdb_paddr[c*6 +: 6] = ($urandom_range(0, 1) == 1) ? 6'(mp[a]) : 6'($urandom_range(32, 39));
            end
            ckpt_take = ($urandom_range(0, 3) == 0);
            ckpt_lane = 1'($urandom_range(0, 1));
            bt = pick_busy();
            if (bt >= 0 && $urandom_range(0, 6) == 0) begin ckpt_free = 1'b1; ckpt_free_tag = 2'(bt); end
            bt = pick_busy();
            if (bt >= 0 && $urandom_range(0, 13) == 0) begin ckpt_restore = 1'b1; ckpt_restore_tag = 2'(bt); end
            #3;
            chk("rnd ckpt_full", int'(ckpt_full), m_full());
            if (m_full() == 0) chk("rnd ckpt_tag", int'(ckpt_tag), m_tag());
            for (int i = 0; i < 2; i++) begin
                ex = m_read(i, int'(rs1_s[i*5 +: 5]));
                chk($sformatf("rnd%0d lane%0d rs1", n, i), int'({rs1_valid[i], rs1_paddr[i*6 +: 6]}), ex);
                ex = m_read(i, int'(rs2_s[i*5 +: 5]));
                chk($sformatf("rnd%0d lane%0d rs2", n, i), int'({rs2_valid[i], rs2_paddr[i*6 +: 6]}), ex);
            end
            model_step();
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
